// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, multiplier FSM state
// encoding and the layout of the EX/MEM pipeline register.
package ex_pkg;

    // Datapath and pipeline-register field widths
    localparam int XLEN_W  = 32;
    localparam int REG_W   = 5;
    localparam int SIZE_W  = 2;
    localparam int OP_W    = 4;
    localparam int SHAMT_W = 5;

    // Multiplier latency counter: wide enough for latencies up to 15
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    // ALU operation codes; codes 11..15 are unassigned and produce zero
    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    // Multiplier FSM state encoding
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } mul_state_e;

    // EX/MEM pipeline register contents; an all-zero value is a bubble
    typedef struct packed {
        logic              valid;
        logic [XLEN_W-1:0] result;
        logic [XLEN_W-1:0] wdata;
        logic [XLEN_W-1:0] pc;
        logic [REG_W-1:0]  rd;
        logic              is_load;
        logic              is_store;
        logic              is_write;
        logic              load_unsigned;
        logic [SIZE_W-1:0] mem_size;
    } exmem_t;

endpackage

// File: rtl/mul_unit.sv
// Fixed-latency multiplier: latches operands on start, counts down the
// latency and flags completion. The counter saturates at 1 so a result that
// is ready but blocked downstream simply waits with done held high.
module mul_unit
    import ex_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            hold,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LATENCY - 1);

    mul_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt_next;

    // Saturating countdown value for the next busy cycle
    always_comb begin
        if (r_cnt > CNT_ONE) begin
            w_cnt_next = r_cnt - CNT_ONE;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Multiplier control FSM with registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state <= ST_MUL_BUSY;
                        r_cnt   <= LAT_M1;
                        r_a     <= a;
                        r_b     <= b;
                        r_busy  <= 1'b1;
                        r_done  <= (LAT_M1 == CNT_ONE);
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_MUL_BUSY: begin
                    if (abort || (r_done && !hold)) begin
                        // Flushed, or product accepted downstream this cycle
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_MUL_BUSY;
                        r_cnt   <= w_cnt_next;
                        r_busy  <= 1'b1;
                        r_done  <= (w_cnt_next == CNT_ONE);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Low word of the product is identical for signed and unsigned operands
    assign product = r_a * r_b;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, multiplier sequencing, stall/flush handling and the
// EX/MEM pipeline register that feeds the MEM stage.
module execute_stage
    import ex_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int XLEN        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm_in,
    input  logic              use_imm,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              is_load_in,
    input  logic              is_store_in,
    input  logic              is_write_in,
    input  logic [SIZE_W-1:0] mem_size_in,
    input  logic              load_unsigned_in,
    input  logic              mem_stall_in,
    input  logic              flush_in,
    output logic              ex_stall,
    output logic              valid_out,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [XLEN-1:0]   write_data_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              is_load_out,
    output logic              is_store_out,
    output logic              is_write_out,
    output logic              load_unsigned_out,
    output logic [SIZE_W-1:0] mem_size_out
);

    logic [XLEN-1:0]    w_op_b;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_alu_result;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_complete;
    logic               w_busy;
    logic               w_done;
    logic [XLEN-1:0]    w_product;
    logic               w_stall;
    exmem_t             w_fill;
    exmem_t             w_next;
    exmem_t             r_exmem;

    // Operand B selection and shift amount
    always_comb begin
        if (use_imm) begin
            w_op_b = imm_in;
        end else begin
            w_op_b = rs2_val;
        end
        w_shamt = w_op_b[SHAMT_W-1:0];
    end

    // Single-cycle ALU; MUL goes through mul_unit so it yields zero here
    always_comb begin
        case (alu_op_e'(alu_op))
            ALU_ADD:  w_alu_result = rs1_val + w_op_b;
            ALU_SUB:  w_alu_result = rs1_val - w_op_b;
            ALU_AND:  w_alu_result = rs1_val & w_op_b;
            ALU_OR:   w_alu_result = rs1_val | w_op_b;
            ALU_XOR:  w_alu_result = rs1_val ^ w_op_b;
            ALU_SLL:  w_alu_result = rs1_val << w_shamt;
            ALU_SRL:  w_alu_result = rs1_val >> w_shamt;
            ALU_SRA:  w_alu_result = $signed(rs1_val) >>> w_shamt;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(w_op_b))};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (rs1_val < w_op_b)};
            default:  w_alu_result = '0;
        endcase
    end

    mul_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .rst_n   (reset),
        .start   (w_mul_start),
        .abort   (flush_in),
        .hold    (mem_stall_in),
        .a       (rs1_val),
        .b       (w_op_b),
        .busy    (w_busy),
        .done    (w_done),
        .product (w_product)
    );

    // Stall generation: MUL launch and in-flight cycles freeze upstream,
    // except the completion cycle so the next instruction advances with it
    always_comb begin
        w_is_mul       = in_valid && (alu_op == ALU_MUL);
        w_mul_start    = w_is_mul && !w_busy && !flush_in;
        w_mul_complete = w_busy && w_done && !mem_stall_in && !flush_in;
        if (!reset) begin
            w_stall = 1'b0;
        end else if (flush_in) begin
            w_stall = 1'b0;
        end else if (w_mul_start) begin
            w_stall = 1'b1;
        end else if (w_busy) begin
            w_stall = !w_mul_complete;
        end else begin
            w_stall = 1'b0;
        end
    end

    assign ex_stall = w_stall;

    // Next EX/MEM contents: hold on MEM stall, bubble on flush or while a MUL occupies EX
    always_comb begin
        w_fill               = '0;
        w_fill.valid         = 1'b1;
        w_fill.result        = w_busy ? w_product : w_alu_result;
        w_fill.wdata         = rs2_val;
        w_fill.pc            = pc_in;
        w_fill.rd            = rd_in;
        w_fill.is_load       = is_load_in;
        w_fill.is_store      = is_store_in;
        w_fill.is_write      = is_write_in;
        w_fill.load_unsigned = load_unsigned_in;
        w_fill.mem_size      = mem_size_in;

        w_next = r_exmem;
        if (mem_stall_in) begin
            w_next = r_exmem;
        end else if (flush_in) begin
            w_next = '0;
        end else if (w_busy) begin
            if (w_mul_complete) begin
                w_next = w_fill;
            end else begin
                w_next = '0;
            end
        end else if (w_is_mul || !in_valid) begin
            w_next = '0;
        end else begin
            w_next = w_fill;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_next;
        end
    end

    assign valid_out         = r_exmem.valid;
    assign alu_result_out    = r_exmem.result;
    assign write_data_out    = r_exmem.wdata;
    assign pc_out            = r_exmem.pc;
    assign rd_out            = r_exmem.rd;
    assign is_load_out       = r_exmem.is_load;
    assign is_store_out      = r_exmem.is_store;
    assign is_write_out      = r_exmem.is_write;
    assign load_unsigned_out = r_exmem.load_unsigned;
    assign mem_size_out      = r_exmem.mem_size;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with an expected-result scoreboard.
module tb_execute_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc_in, rs1_val, rs2_val, imm_in;
    logic        use_imm;
    logic [3:0]  alu_op;
    logic [4:0]  rd_in;
    logic        is_load_in, is_store_in, is_write_in, load_unsigned_in;
    logic [1:0]  mem_size_in;
    logic        mem_stall_in, flush_in;
    logic        ex_stall, valid_out;
    logic [31:0] alu_result_out, write_data_out, pc_out;
    logic [4:0]  rd_out;
    logic        is_load_out, is_store_out, is_write_out, load_unsigned_out;
    logic [1:0]  mem_size_out;

    always #5 clk = ~clk;

    execute_stage #(.MUL_LATENCY(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm_in(imm_in), .use_imm(use_imm),
        .alu_op(alu_op), .rd_in(rd_in), .is_load_in(is_load_in),
        .is_store_in(is_store_in), .is_write_in(is_write_in),
        .mem_size_in(mem_size_in), .load_unsigned_in(load_unsigned_in),
        .mem_stall_in(mem_stall_in), .flush_in(flush_in), .ex_stall(ex_stall),
        .valid_out(valid_out), .alu_result_out(alu_result_out),
        .write_data_out(write_data_out), .pc_out(pc_out), .rd_out(rd_out),
        .is_load_out(is_load_out), .is_store_out(is_store_out),
        .is_write_out(is_write_out), .load_unsigned_out(load_unsigned_out),
        .mem_size_out(mem_size_out)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [5:0]  ctl;   // {ld, st, wr, lu, size}
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc_ctr  = 32'h0000_1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU written independently of the RTL
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [63:0]        p;
        sa = a;
        sb = b;
        p  = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0:    return a + b;
            4'd1:    return a + (~b) + 32'd1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'(sa >>> b[4:0]);
            4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        in_valid = 1'b0; use_imm = 1'b0; alu_op = 4'd0; flush_in = 1'b0;
        mem_stall_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
        is_write_in = 1'b0; load_unsigned_in = 1'b0; mem_size_in = 2'b00;
        rs1_val = 32'd0; rs2_val = 32'd0; imm_in = 32'd0; rd_in = 5'd0; pc_in = 32'd0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic ui);
        in_valid = 1'b1; alu_op = op; rs1_val = a; rs2_val = b; imm_in = imm; use_imm = ui;
        is_load_in = 1'b0; is_store_in = 1'b0; is_write_in = 1'b1; load_unsigned_in = 1'b0;
        mem_size_in = 2'b10; rd_in = 5'($urandom_range(1, 31));
        pc_ctr = pc_ctr + 32'd4; pc_in = pc_ctr;
    endtask

    task automatic push_exp();
        exp_t e;
        e.res = model(alu_op, rs1_val, use_imm ? imm_in : rs2_val);
        e.wd  = rs2_val;
        e.pc  = pc_in;
        e.rd  = rd_in;
        e.ctl = {is_load_in, is_store_in, is_write_in, load_unsigned_in, mem_size_in};
        sb_q.push_back(e);
    endtask

    // One clock; pops and compares when the EX/MEM register loaded a valid entry
    task automatic tick();
        logic  frozen;
        exp_t  e;
        frozen = mem_stall_in || !reset;
        @(posedge clk);
        #1;
        if (!frozen && valid_out === 1'b1) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("result", alu_result_out, e.res);
                chk("wdata", write_data_out, e.wd);
                chk("pc", pc_out, e.pc);
                chk("rd", 32'(rd_out), 32'(e.rd));
                chk("ctrl", 32'({is_load_out, is_store_out, is_write_out,
                                 load_unsigned_out, mem_size_out}), 32'(e.ctl));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid_out), 32'd0);
        chk({tag, "_result"}, alu_result_out, 32'd0);
        chk({tag, "_wdata"}, write_data_out, 32'd0);
        chk({tag, "_pc"}, pc_out, 32'd0);
        chk({tag, "_ctrl"}, 32'({rd_out, is_load_out, is_store_out, is_write_out,
                                 load_unsigned_out, mem_size_out}), 32'd0);
        chk({tag, "_stall"}, 32'(ex_stall), 32'd0);
    endtask

    initial begin
        // Reset with random inputs, including a MUL presented
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
            if (i == 0) alu_op = ALU_MUL;
            mem_stall_in = 1'($urandom); flush_in = 1'b0;
            @(posedge clk);
            #2;
            chk_all_zero("reset");
        end
        idle();
        reset = 1'b1;
        tick();

        // ADD 5 + 7
        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0); push_exp();
        #1 chk("add_no_stall", 32'(ex_stall), 32'd0);
        tick();
        chk("add_valid", 32'(valid_out), 32'd1);

        // Store: address rs1 + imm, data rs2
        drive(ALU_ADD, 32'h100, 32'hAB, 32'h8, 1'b1);
        is_store_in = 1'b1; is_write_in = 1'b0; mem_size_in = 2'b10; push_exp();
        tick();
        chk("store_addr", alu_result_out, 32'h108);
        chk("store_data", write_data_out, 32'hAB);
        // Unsigned byte load
        drive(ALU_ADD, 32'h200, 32'h0, 32'hFFFF_FFFC, 1'b1);
        is_load_in = 1'b1; load_unsigned_in = 1'b1; mem_size_in = 2'b00; push_exp();
        tick();
        idle();
        tick();

        // MUL 7 * -3: stall exactly three cycles, bubbles meanwhile
        drive(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0); push_exp();
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("mul_stall_c%0d", c), 32'(ex_stall), 32'(c < 3));
            tick();
            if (c < 3) chk($sformatf("mul_bubble_c%0d", c), 32'(valid_out), 32'd0);
        end
        chk("mul_product", alu_result_out, 32'hFFFF_FFEB);
        idle();
        tick();
        chk("mul_once", 32'(valid_out), 32'd0);

        // MUL with MEM stall in cycles 2..5
        drive(ALU_MUL, 32'h0001_2345, 32'h0000_0100, 32'd0, 1'b0); push_exp();
        for (int c = 0; c < 7; c++) begin
            mem_stall_in = (c >= 2 && c <= 5);
            #1 chk($sformatf("mstall_stall_c%0d", c), 32'(ex_stall), 32'(c < 6));
            tick();
            if (c < 6) chk($sformatf("mstall_bubble_c%0d", c), 32'(valid_out), 32'd0);
        end
        chk("mstall_product", alu_result_out, 32'h0123_4500);
        idle();
        tick();
        chk("mstall_once", 32'(valid_out), 32'd0);
        chk("mstall_drained", 32'(sb_q.size()), 32'd0);

        // Flush in cycle 1 of a MUL, then ADD 1 + 1
        drive(ALU_MUL, 32'd9, 32'd9, 32'd0, 1'b0);
        tick();
        flush_in = 1'b1;
        #1 chk("flush_stall", 32'(ex_stall), 32'd0);
        tick();
        chk("flush_bubble", 32'(valid_out), 32'd0);
        flush_in = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0); push_exp();
        #1 chk("post_flush_idle", 32'(ex_stall), 32'd0);
        tick();
        chk("post_flush_add", alu_result_out, 32'd2);

        // Non-MUL under MEM stall: EX/MEM holds, no ex_stall
        drive(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_4321, 32'd0, 1'b0); push_exp();
        mem_stall_in = 1'b1;
        #1 chk("hold_no_stall", 32'(ex_stall), 32'd0);
        tick();
        chk("hold_valid", 32'(valid_out), 32'd1);
        chk("hold_result", alu_result_out, 32'd2);
        mem_stall_in = 1'b0;
        tick();

        // SLT/SLTU boundary and arithmetic shift
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); push_exp(); tick();
        chk("slt", alu_result_out, 32'd1);
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); push_exp(); tick();
        chk("sltu", alu_result_out, 32'd0);
        drive(ALU_SRA, 32'h8000_0000, 32'd0, 32'd4, 1'b1); push_exp(); tick();
        chk("sra", alu_result_out, 32'hF800_0000);

        // Back-to-back sweep over every non-MUL code with random operands
        for (int op = 0; op < 16; op++) begin
            if (op != 10) begin
                drive(4'(op), $urandom, $urandom, $urandom, 1'($urandom));
                push_exp();
                tick();
            end
        end
        idle();
        tick();

        // Reset asserted mid-MUL
        drive(ALU_MUL, 32'd5, 32'd6, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1 chk_all_zero("midmul_reset");
        idle();
        @(posedge clk);
        #1 reset = 1'b1;
        drive(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0); push_exp();
        #1 chk("post_reset_idle", 32'(ex_stall), 32'd0);
        tick();
        chk("post_reset_add", alu_result_out, 32'd7);
        idle();
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
